ps2_kbd_tx: RTL and testbench

- PS/2 keyboard device-side transmitter.
- Serialises scancode bytes into PS/2 clock/data lines, the same signals the keyboard receiver in glue consumes.
- Replaces the SPI-bridged keyboard path when scancodes come from an on-chip source (for example a matrix scanner or a test injector).
- Sits in the 35.468 MHz `clock` domain. Contains a small input FIFO and a frame/bit-timing state machine.

---
 rtl/ps2_kbd_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard device-side transmitter: small byte FIFO feeding an 11-bit frame serialiser.
// Optional host-inhibit handling (inhibit port, HOLD/retry) is built when PS2_TX_INHIBIT_EN is defined.
module ps2_kbd_tx #(
    parameter int HALF       = 1773,
    parameter int DEPTH_LOG2 = 2,
    parameter int GAP_BITS   = 2
) (
    input  logic       clock,
    input  logic       power,
    input  logic [7:0] data,
    input  logic       strobe,
    output logic       ready,
    output logic       busy,
    output logic       ps2Ck,
    output logic       ps2Dq
`ifdef PS2_TX_INHIBIT_EN
    ,
    input  logic       inhibit
`endif
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int GAP_CYC = GAP_BITS * 2 * HALF;
    localparam int GW      = $clog2(GAP_CYC + 1);
    localparam logic [15:0]           HALF_LAST = 16'(HALF - 1);
    localparam logic [DEPTH_LOG2:0]   FULL      = (DEPTH_LOG2 + 1)'(DEPTH);
    // GAP exits two cycles early: the IDLE and LOAD cycles complete the idle interval.
    localparam logic [GW-1:0]         GAP_LAST  = GW'(GAP_CYC - 3);

`ifdef PS2_TX_INHIBIT_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
`endif

    state_t                state;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  pending;
    logic                  do_push;
    logic                  do_pop;
    logic [7:0]            cur_byte;
    logic [9:0]            shreg;
    logic [3:0]            bit_idx;
    logic                  phase_low;
    logic [15:0]           cnt;
    logic [GW-1:0]         gcnt;

`ifdef PS2_TX_INHIBIT_EN
    logic       inh_meta;
    logic       inh_s;
    logic       retry;
    logic [7:0] retry_byte;
`endif

    always_comb begin
        do_push = strobe & ready;
`ifdef PS2_TX_INHIBIT_EN
        do_pop   = (state == LOAD) & ~retry;
        cur_byte = retry ? retry_byte : mem[rd_ptr];
`else
        do_pop   = (state == LOAD);
        cur_byte = mem[rd_ptr];
`endif
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pending   <= 1'b0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            ps2Ck     <= 1'b1;
            ps2Dq     <= 1'b1;
            shreg     <= '1;
            bit_idx   <= '0;
            phase_low <= 1'b0;
            cnt       <= '0;
            gcnt      <= '0;
`ifdef PS2_TX_INHIBIT_EN
            inh_meta   <= 1'b0;
            inh_s      <= 1'b0;
            retry      <= 1'b0;
            retry_byte <= '0;
`endif
        end else begin
            count   <= count_next;
            ready   <= (count_next < FULL);
            pending <= (count != '0);
            busy    <= (count_next != '0) || (state != IDLE);
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
`ifdef PS2_TX_INHIBIT_EN
            inh_meta <= inhibit;
            inh_s    <= inh_meta;
`endif
            case (state)
                IDLE: begin
                    ps2Ck <= 1'b1;
                    ps2Dq <= 1'b1;
`ifdef PS2_TX_INHIBIT_EN
                    if (pending && !inh_s) state <= LOAD;
`else
                    if (pending) state <= LOAD;
`endif
                end
                LOAD: begin
                    // Frame bits 1..10 wait in shreg; bit 0 (start) goes straight to the line.
                    shreg     <= {1'b1, ~^cur_byte, cur_byte};
                    ps2Ck     <= 1'b1;
                    ps2Dq     <= 1'b0;
                    bit_idx   <= '0;
                    phase_low <= 1'b0;
                    cnt       <= '0;
                    state     <= SEND;
`ifdef PS2_TX_INHIBIT_EN
                    retry_byte <= cur_byte;
                    retry      <= 1'b0;
`endif
                end
                SEND: begin
`ifdef PS2_TX_INHIBIT_EN
                    if (inh_s && !(bit_idx == 4'd10 && phase_low)) begin
                        ps2Ck <= 1'b1;
                        ps2Dq <= 1'b1;
                        retry <= 1'b1;
                        state <= HOLD;
                    end else
`endif
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!phase_low) begin
                            ps2Ck     <= 1'b0;
                            phase_low <= 1'b1;
                        end else begin
                            ps2Ck     <= 1'b1;
                            phase_low <= 1'b0;
                            if (bit_idx == 4'd10) begin
                                ps2Dq <= 1'b1;
                                gcnt  <= '0;
                                state <= GAP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                                ps2Dq   <= shreg[0];
                                shreg   <= {1'b1, shreg[9:1]};
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    ps2Ck <= 1'b1;
                    ps2Dq <= 1'b1;
                    if (gcnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= (count_next != '0);
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
`ifdef PS2_TX_INHIBIT_EN
                HOLD: begin
                    ps2Ck <= 1'b1;
                    ps2Dq <= 1'b1;
                    if (!inh_s) state <= LOAD;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx (HALF=4, GAP_BITS=2, depth 4); a line monitor rebuilds frames
// from ps2Dq at each ps2Ck fall and a scoreboard compares them with hand-computed frame words.
module tb_ps2_kbd_tx;
    localparam int HALF = 4;

    logic       clock = 1'b0;
    logic       power = 1'b0;
    logic       strobe = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready;
    logic       busy;
    logic       ps2Ck;
    logic       ps2Dq;
`ifdef PS2_TX_INHIBIT_EN
    logic       inhibit = 1'b0;
`endif

    ps2_kbd_tx #(.HALF(HALF), .DEPTH_LOG2(2), .GAP_BITS(2)) dut (
        .clock  (clock),
        .power  (power),
        .data   (data),
        .strobe (strobe),
        .ready  (ready),
        .busy   (busy),
        .ps2Ck  (ps2Ck),
        .ps2Dq  (ps2Dq)
`ifdef PS2_TX_INHIBIT_EN
        ,
        .inhibit(inhibit)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Line monitor: frames are 11-bit words, bit 0 = first bit on the wire.
    logic [10:0] frame_q[$];
    int          start_q[$];
    int          end_q[$];
    logic [10:0] mon_word = '0;
    int          mon_nbits = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          ck_hi = 0;
    logic        prev_ck = 1'b1;
    logic        prev_dq = 1'b1;

    always @(negedge clock) begin
        cyc++;
        if (!power) begin
            mon_nbits = 0;
            ck_hi     = 0;
            prev_ck   = 1'b1;
            prev_dq   = 1'b1;
        end else begin
            if (prev_ck && !ps2Ck) begin
                mon_word = {ps2Dq, mon_word[10:1]};
                mon_nbits++;
            end
            if (!prev_ck && ps2Ck && mon_nbits == 11) begin
                frame_q.push_back(mon_word);
                start_q.push_back(start_cyc);
                end_q.push_back(cyc);
                mon_nbits = 0;
            end
            if (mon_nbits == 0 && prev_dq && !ps2Dq && ps2Ck) start_cyc = cyc;
            ck_hi = ps2Ck ? ck_hi + 1 : 0;
            // A clock-high stretch longer than a half period means the frame was abandoned.
            if (ck_hi > HALF && mon_nbits != 0) mon_nbits = 0;
            prev_ck = ps2Ck;
            prev_dq = ps2Dq;
        end
    end

    logic [10:0] exp_q[$];
    int          scored = 0;

    task automatic score(input string tag);
        check({tag, "_count"}, frame_q.size(), exp_q.size());
        for (int k = scored; k < exp_q.size(); k++) check({tag, "_frame"}, frame_q[k], exp_q[k]);
        scored = exp_q.size();
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clock);
        strobe = 1'b1;
        data   = b;
        @(negedge clock);
        strobe = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (frame_q.size() < n && t < budget) begin
            @(negedge clock);
            t++;
        end
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy !== 1'b0 && t < budget) begin
            @(negedge clock);
            t++;
        end
    endtask

    initial begin
        int k;
        int base;
        repeat (3) @(negedge clock);
        check("rst_ck", ps2Ck, 1);
        check("rst_dq", ps2Dq, 1);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        power = 1'b1;
        repeat (3) @(negedge clock);

        // 0x1C: start bit three edges after accept, 22*HALF cycles of frame.
        put(8'h1C);
        exp_q.push_back(11'h438);
        k = 0;
        while (ps2Dq !== 1'b0 && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("start_latency", k, 3);
        wait_frames(1, 500);
        score("f1c");
        check("f1c_len", end_q[0] - start_q[0], 88);
        wait_idle(500);
        check("f1c_idle_busy", busy, 0);

        // Back-to-back 0xF0, 0x00: idle interval between frames is exactly 16 cycles.
        base = frame_q.size();
        @(negedge clock);
        strobe = 1'b1;
        data   = 8'hF0;
        @(negedge clock);
        data   = 8'h00;
        @(negedge clock);
        strobe = 1'b0;
        exp_q.push_back(11'h7E0);
        exp_q.push_back(11'h600);
        wait_frames(base + 2, 1000);
        score("b2b");
        check("b2b_len", end_q[base + 1] - start_q[base + 1], 88);
        check("b2b_gap", start_q[base + 1] - end_q[base], 16);
        wait_idle(500);

        // FIFO fill while a frame is on the wire; 5th strobe dropped, held strobe waits for ready.
        put(8'h11);
        exp_q.push_back(11'h622);
        repeat (8) @(negedge clock);
        strobe = 1'b1;
        data   = 8'h22;
        @(negedge clock);
        data = 8'h33;
        @(negedge clock);
        data = 8'h44;
        @(negedge clock);
        data = 8'h55;
        check("fill_ready_before_4th", ready, 1);
        @(negedge clock);
        check("fill_ready_full", ready, 0);
        data = 8'h66;
        @(negedge clock);
        strobe = 1'b0;
        exp_q.push_back(11'h644);
        exp_q.push_back(11'h666);
        exp_q.push_back(11'h688);
        exp_q.push_back(11'h6AA);
        k = 0;
        while (ready !== 1'b1 && k < 1000) begin
            @(negedge clock);
            k++;
        end
        check("fill_ready_after_pop", ready, 1);
        strobe = 1'b1;
        data   = 8'h77;
        @(negedge clock);
        strobe = 1'b0;
        exp_q.push_back(11'h6EE);
        wait_idle(5000);
        score("fill");
        check("fill_busy", busy, 0);
        check("fill_ready_end", ready, 1);

        // Power drop during the low half of bit 5 of 0xAB (d4 = 0 on the line).
        put(8'hAB);
        k = 0;
        while (!(mon_nbits == 6 && ps2Ck == 1'b0) && k < 1000) begin
            @(negedge clock);
            k++;
        end
        check("rst_mid_reached", {ps2Ck, ps2Dq, busy}, 3'b001);
        #3 power = 1'b0;
        #1;
        check("rst_mid_ck", ps2Ck, 1);
        check("rst_mid_dq", ps2Dq, 1);
        check("rst_mid_ready", ready, 1);
        check("rst_mid_busy", busy, 0);
        repeat (3) @(negedge clock);
        power = 1'b1;
        repeat (300) @(negedge clock);
        check("rst_no_residual", frame_q.size(), exp_q.size());
        check("rst_busy_after", busy, 0);

`ifdef PS2_TX_INHIBIT_EN
        // Inhibit during bit 3 of 0x1C: lines high within 3 cycles, then one full resend.
        put(8'h1C);
        k = 0;
        while (!(mon_nbits == 4 && ps2Ck == 1'b0) && k < 1000) begin
            @(negedge clock);
            k++;
        end
        inhibit = 1'b1;
        repeat (3) @(negedge clock);
        check("inh_lines_high", {ps2Ck, ps2Dq}, 2'b11);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if ({ps2Ck, ps2Dq} != 2'b11) k++;
        end
        check("inh_held_high", k, 0);
        inhibit = 1'b0;
        exp_q.push_back(11'h438);
        wait_idle(2000);
        repeat (100) @(negedge clock);
        score("inh");
        check("inh_busy", busy, 0);
        check("inh_ready", ready, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
